pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Generates per-stage stall (hold) and flush (bubble) controls and EX-stage forwarding selects.
//  It also owns the multi-cycle DRAM wait FSM with a watchdog, plus stall/flush perf counters.
//  Sits beside the pipeline registers in the core top; purely control, no datapath.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max MEM_WAIT cycles before the watchdog trips (>=2)
//  CNT_W           32   width of perf counters (saturating)
//  FWD_EN          1    1: EX forwarding from MEM/WB; 0: every ID RAW on an EX/MEM producer stalls
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   synchronous, active-high reset
//  id_rs1_i/id_rs2_i in  5   source regs of instr in ID
//  id_rs1_use_i/id_rs2_use_i in 1  source actually read
//  ex_rs1_i/ex_rs2_i in  5   source regs of instr in EX (forwarding compare)
//  ex_valid_i, ex_rf_we_i, ex_is_load_i  in 1  EX-stage producer info
//  ex_wr_i          in   5   EX destination
//  mem_valid_i, mem_rf_we_i, mem_is_load_i in 1  MEM-stage producer info
//  mem_wr_i         in   5   MEM destination
//  wb_valid_i, wb_rf_we_i in 1; wb_wr_i in 5   WB producer info
//  redirect_i       in   1   taken branch/jump resolved in EX
//  dram_req_i       in   1   MEM-stage instr accesses DRAM this cycle
//  dram_ready_i     in   1   DRAM completes access this cycle
//  stall_if_o, stall_id_o, stall_ex_o, stall_mem_o  out 1  hold PC / IF/ID / ID/EX / EX/MEM
//  flush_id_o, flush_ex_o  out 1  bubble into IF/ID / ID/EX (valid=0, rf_we=0)
//  bubble_wb_o      out  1   MEM/WB loads instr_valid=0, rf_we=0
//  fwd_rs1_o/fwd_rs2_o out 2 EX operand source: 00 regfile, 01 MEM alu result, 10 WB data
//  mem_timeout_o    out  1   sticky watchdog error
//  stall_cnt_o      out  CNT_W  cycles with stall_if_o=1
//  flush_cnt_o      out  CNT_W  accepted redirects
// BEHAVIOUR
//  Reset (rst=1 at edge): state=RUN, wait counter=0, mem_timeout_o=0, perf counters=0.
//   While rst=1, all stall/flush/bubble outputs forced 0 and fwd_* = 00. Mid-MEM_WAIT reset -> RUN.
//  Match(rs,wr) = rs!=0 & use & valid & rf_we & rs==wr.
//  Memory wait mw = (state==MEM_WAIT & !dram_ready_i) | (state==RUN & dram_req_i & !dram_ready_i)
//   | state==TIMEOUT.
//  Load-use lu = Match(id,EX) & ex_is_load | Match(id,MEM) & mem_is_load (2 bubbles; DRAM data at WB).
//   With FWD_EN=0, lu also covers any Match(id,EX)|Match(id,MEM). WB producers never stall (RF bypass).
//  Priority (combinational, same cycle):
//   1. mw: stall_if/id/ex/mem=1, bubble_wb=1, flushes=0, redirect ignored (branch held in EX).
//   2. redirect_i: flush_id=1, flush_ex=1, no stalls; flush_cnt++.
//   3. lu: stall_if=1, stall_id=1, flush_ex=1.
//   4. else all 0.
//  FSM: RUN -> MEM_WAIT when dram_req_i & !dram_ready_i (cnt<=1).
//   MEM_WAIT: cnt++. dram_ready_i -> RUN; that cycle has no mem stall, so the pipe advances.
//   cnt==TIMEOUT_CYCLES & !dram_ready_i -> TIMEOUT; mem_timeout_o<=1.
//   TIMEOUT: permanent full stall until rst. Single-cycle DRAM (ready with req) never leaves RUN.
//  Forwarding (EX): Match(ex_rs,MEM) & !mem_is_load -> 01; else Match(ex_rs,WB) -> 10; else 00.
//   MEM beats WB. FWD_EN=0 -> always 00.
//  Counters saturate at all-ones; stall_cnt counts every cycle stall_if_o=1, incl. TIMEOUT.
// STRUCTURE
//  pipeline_ctrl_pkg: ctrl_state_e {RUN, MEM_WAIT, TIMEOUT}; fwd_sel_e {FWD_RF=2'b00, FWD_MEM=2'b01,
//   FWD_WB=2'b10}; used by EX operand muxes.
//  Sub-module hazard_detect: combinational Match/lu/fwd logic; parent owns FSM, priority, counters.
// TESTING
//  ld x5 in EX, ID add reads x5 -> 2 cycles stall_if/id=1, flush_ex=1; then fwd_rs1=10 in EX.
//  add x5 in MEM, EX reads x5 and x5 also in WB -> fwd=01 (MEM priority); rs=x0 -> 00.
//  dram_req with ready after 3 cycles -> stall_mem=1, bubble_wb=1 for 3 cycles; 4th cycle all 0.
//  redirect_i during MEM_WAIT -> no flush until wait ends; then flush_id/ex=1, flush_cnt=1.
//  TIMEOUT_CYCLES=4, ready never -> mem_timeout_o=1 after 4 wait cycles, stalls stay; rst clears.
//  redirect_i with lu in same cycle -> flush_id/ex=1, stall_if=0; rst mid-wait -> RUN, counters 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and the EX operand muxes.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    TIMEOUT  = 2'b10
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // True when a consumer source register is produced by an in-flight writer.
  function automatic logic reg_match(input logic [4:0] rs, input logic use_rs,
                                     input logic valid, input logic rf_we,
                                     input logic [4:0] wr);
    return (rs != 5'd0) && use_rs && valid && rf_we && (rs == wr);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW detection: load-use stall request for ID and forwarding selects for EX.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned FWD_EN = 1
) (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_use_i,
  input  logic       id_rs2_use_i,
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_rf_we_i,
  input  logic       ex_is_load_i,
  input  logic [4:0] ex_wr_i,
  input  logic       mem_valid_i,
  input  logic       mem_rf_we_i,
  input  logic       mem_is_load_i,
  input  logic [4:0] mem_wr_i,
  input  logic       wb_valid_i,
  input  logic       wb_rf_we_i,
  input  logic [4:0] wb_wr_i,
  output logic       load_use_o,
  output logic [1:0] fwd_rs1_o,
  output logic [1:0] fwd_rs2_o
);

  localparam bit FwdOn = (FWD_EN != 0);

  logic id_ex_hit, id_mem_hit;

  assign id_ex_hit  = reg_match(id_rs1_i, id_rs1_use_i, ex_valid_i, ex_rf_we_i, ex_wr_i) |
                      reg_match(id_rs2_i, id_rs2_use_i, ex_valid_i, ex_rf_we_i, ex_wr_i);
  assign id_mem_hit = reg_match(id_rs1_i, id_rs1_use_i, mem_valid_i, mem_rf_we_i, mem_wr_i) |
                      reg_match(id_rs2_i, id_rs2_use_i, mem_valid_i, mem_rf_we_i, mem_wr_i);

  // WB producers never stall: the register file bypasses same-cycle writes.
  assign load_use_o = FwdOn ? ((id_ex_hit & ex_is_load_i) | (id_mem_hit & mem_is_load_i))
                            : (id_ex_hit | id_mem_hit);

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (FwdOn) begin
      // Load data only exists at WB, so a MEM-stage load cannot be a forwarding source.
      if (reg_match(rs, 1'b1, mem_valid_i, mem_rf_we_i, mem_wr_i) && !mem_is_load_i) begin
        sel = FWD_MEM;
      end else if (reg_match(rs, 1'b1, wb_valid_i, wb_rf_we_i, wb_wr_i)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  assign fwd_rs1_o = fwd_sel(ex_rs1_i);
  assign fwd_rs2_o = fwd_sel(ex_rs2_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush sequencer with DRAM wait FSM, watchdog and saturating perf counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned FWD_EN         = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_use_i,
  input  logic             id_rs2_use_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic             ex_valid_i,
  input  logic             ex_rf_we_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_wr_i,
  input  logic             mem_valid_i,
  input  logic             mem_rf_we_i,
  input  logic             mem_is_load_i,
  input  logic [4:0]       mem_wr_i,
  input  logic             wb_valid_i,
  input  logic             wb_rf_we_i,
  input  logic [4:0]       wb_wr_i,
  input  logic             redirect_i,
  input  logic             dram_req_i,
  input  logic             dram_ready_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             bubble_wb_o,
  output logic [1:0]       fwd_rs1_o,
  output logic [1:0]       fwd_rs2_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(TIMEOUT_CYCLES);

  ctrl_state_e      state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       load_use;
  logic [1:0] hd_fwd_rs1, hd_fwd_rs2;
  logic       mem_wait;
  logic       redirect_acc;

  hazard_detect #(
    .FWD_EN (FWD_EN)
  ) u_hazard_detect (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_use_i  (id_rs1_use_i),
    .id_rs2_use_i  (id_rs2_use_i),
    .ex_rs1_i      (ex_rs1_i),
    .ex_rs2_i      (ex_rs2_i),
    .ex_valid_i    (ex_valid_i),
    .ex_rf_we_i    (ex_rf_we_i),
    .ex_is_load_i  (ex_is_load_i),
    .ex_wr_i       (ex_wr_i),
    .mem_valid_i   (mem_valid_i),
    .mem_rf_we_i   (mem_rf_we_i),
    .mem_is_load_i (mem_is_load_i),
    .mem_wr_i      (mem_wr_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rf_we_i    (wb_rf_we_i),
    .wb_wr_i       (wb_wr_i),
    .load_use_o    (load_use),
    .fwd_rs1_o     (hd_fwd_rs1),
    .fwd_rs2_o     (hd_fwd_rs2)
  );

  assign mem_wait = ((state_q == MEM_WAIT) && !dram_ready_i) ||
                    ((state_q == RUN) && dram_req_i && !dram_ready_i) ||
                    (state_q == TIMEOUT);

  // A redirect during a memory wait stays in EX and is taken once the wait clears.
  assign redirect_acc = !rst && !mem_wait && redirect_i;

  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    bubble_wb_o = 1'b0;
    fwd_rs1_o   = FWD_RF;
    fwd_rs2_o   = FWD_RF;
    if (!rst) begin
      fwd_rs1_o = hd_fwd_rs1;
      fwd_rs2_o = hd_fwd_rs2;
      if (mem_wait) begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        stall_mem_o = 1'b1;
        bubble_wb_o = 1'b1;
      end else if (redirect_i) begin
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end else if (load_use) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      RUN: begin
        if (dram_req_i && !dram_ready_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WaitW'(1);
        end
      end
      MEM_WAIT: begin
        if (dram_ready_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TimeoutVal) begin
          state_d   = TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      TIMEOUT: state_d = TIMEOUT;
      default: state_d = RUN;
    endcase
  end

  assign stall_cnt_d = (stall_if_o && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                            : stall_cnt_q;
  assign flush_cnt_d = (redirect_acc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1)
                                                             : flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (short watchdog, 4-bit counters).
module tb_pipeline_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_wr, mem_wr, wb_wr;
  logic       id_rs1_use, id_rs2_use;
  logic       ex_valid, ex_rf_we, ex_is_load;
  logic       mem_valid, mem_rf_we, mem_is_load;
  logic       wb_valid, wb_rf_we;
  logic       redirect, dram_req, dram_ready;

  logic       stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic       mem_timeout;
  logic [3:0] stall_cnt, flush_cnt;

  logic       b_stall_if, b_stall_id, b_stall_ex, b_stall_mem, b_flush_id, b_flush_ex;
  logic       b_bubble_wb, b_mem_timeout;
  logic [1:0] b_fwd_rs1, b_fwd_rs2;
  logic [3:0] b_stall_cnt, b_flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(4), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_valid_i(ex_valid), .ex_rf_we_i(ex_rf_we),
    .ex_is_load_i(ex_is_load), .ex_wr_i(ex_wr), .mem_valid_i(mem_valid),
    .mem_rf_we_i(mem_rf_we), .mem_is_load_i(mem_is_load), .mem_wr_i(mem_wr),
    .wb_valid_i(wb_valid), .wb_rf_we_i(wb_rf_we), .wb_wr_i(wb_wr), .redirect_i(redirect),
    .dram_req_i(dram_req), .dram_ready_i(dram_ready),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
    .stall_mem_o(stall_mem), .flush_id_o(flush_id), .flush_ex_o(flush_ex),
    .bubble_wb_o(bubble_wb), .fwd_rs1_o(fwd_rs1), .fwd_rs2_o(fwd_rs2),
    .mem_timeout_o(mem_timeout), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(4), .FWD_EN(0)) dut_nofwd (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_valid_i(ex_valid), .ex_rf_we_i(ex_rf_we),
    .ex_is_load_i(ex_is_load), .ex_wr_i(ex_wr), .mem_valid_i(mem_valid),
    .mem_rf_we_i(mem_rf_we), .mem_is_load_i(mem_is_load), .mem_wr_i(mem_wr),
    .wb_valid_i(wb_valid), .wb_rf_we_i(wb_rf_we), .wb_wr_i(wb_wr), .redirect_i(redirect),
    .dram_req_i(dram_req), .dram_ready_i(dram_ready),
    .stall_if_o(b_stall_if), .stall_id_o(b_stall_id), .stall_ex_o(b_stall_ex),
    .stall_mem_o(b_stall_mem), .flush_id_o(b_flush_id), .flush_ex_o(b_flush_ex),
    .bubble_wb_o(b_bubble_wb), .fwd_rs1_o(b_fwd_rs1), .fwd_rs2_o(b_fwd_rs2),
    .mem_timeout_o(b_mem_timeout), .stall_cnt_o(b_stall_cnt), .flush_cnt_o(b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_valid = 0; ex_rf_we = 0; ex_is_load = 0; ex_wr = 0;
    mem_valid = 0; mem_rf_we = 0; mem_is_load = 0; mem_wr = 0;
    wb_valid = 0; wb_rf_we = 0; wb_wr = 0;
    redirect = 0; dram_req = 0; dram_ready = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    // Reset forces outputs low even with stall-causing inputs present.
    rst = 1; dram_req = 1; redirect = 1;
    cyc(); cyc();
    chk("rst_stall_if", stall_if, 0);
    chk("rst_flush_id", flush_id, 0);
    chk("rst_bubble_wb", bubble_wb, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    rst = 0; clr(); settle();
    chk("idle_stall_if", stall_if, 0);

    // Load-use: ld x5 in EX, ID reads x5.
    ex_valid = 1; ex_rf_we = 1; ex_is_load = 1; ex_wr = 5; id_rs1 = 5; id_rs1_use = 1;
    settle();
    chk("lu1_stall_if", stall_if, 1);
    chk("lu1_stall_id", stall_id, 1);
    chk("lu1_flush_ex", flush_ex, 1);
    chk("lu1_stall_ex", stall_ex, 0);
    cyc();
    ex_valid = 0; ex_rf_we = 0; ex_is_load = 0; ex_wr = 0;
    mem_valid = 1; mem_rf_we = 1; mem_is_load = 1; mem_wr = 5;
    settle();
    chk("lu2_stall_if", stall_if, 1);
    chk("lu2_flush_ex", flush_ex, 1);
    cyc();
    clr(); wb_valid = 1; wb_rf_we = 1; wb_wr = 5; ex_rs1 = 5;
    settle();
    chk("lu3_stall_if", stall_if, 0);
    chk("lu3_fwd_rs1_wb", fwd_rs1, 2'b10);
    chk("lu3_stall_cnt", stall_cnt, 2);

    // MEM beats WB; x0 never forwards; MEM load falls back to WB.
    mem_valid = 1; mem_rf_we = 1; mem_wr = 5; ex_rs2 = 0;
    settle();
    chk("fwd_mem_prio", fwd_rs1, 2'b01);
    chk("fwd_x0", fwd_rs2, 2'b00);
    mem_is_load = 1;
    settle();
    chk("fwd_memload_wb", fwd_rs1, 2'b10);

    // FWD_EN=0: ID RAW on a non-load MEM producer stalls and forwarding is off.
    mem_is_load = 0; id_rs1 = 5; id_rs1_use = 1;
    settle();
    chk("fwd_on_no_stall", stall_if, 0);
    chk("fwd_off_stall", b_stall_if, 1);
    chk("fwd_off_sel", b_fwd_rs1, 2'b00);

    rst = 1; clr(); cyc(); rst = 0;

    // DRAM ready on 4th cycle; redirect arrives mid-wait.
    dram_req = 1;
    settle();
    chk("dw0_stall_mem", stall_mem, 1);
    chk("dw0_bubble_wb", bubble_wb, 1);
    cyc(); redirect = 1; settle();
    chk("dw1_stall_if", stall_if, 1);
    chk("dw1_no_flush", flush_id, 0);
    cyc(); settle();
    chk("dw2_stall_mem", stall_mem, 1);
    cyc(); dram_ready = 1; settle();
    chk("dw3_stall_mem", stall_mem, 0);
    chk("dw3_bubble_wb", bubble_wb, 0);
    chk("dw3_flush_id", flush_id, 1);
    chk("dw3_flush_ex", flush_ex, 1);
    cyc(); clr(); settle();
    chk("dw_flush_cnt", flush_cnt, 1);
    chk("dw_stall_cnt", stall_cnt, 3);
    chk("dw_idle_stall", stall_mem, 0);

    // Redirect wins over load-use.
    ex_valid = 1; ex_rf_we = 1; ex_is_load = 1; ex_wr = 5; id_rs1 = 5; id_rs1_use = 1;
    redirect = 1;
    settle();
    chk("rdlu_flush_id", flush_id, 1);
    chk("rdlu_flush_ex", flush_ex, 1);
    chk("rdlu_stall_if", stall_if, 0);
    cyc(); clr(); settle();
    chk("rdlu_flush_cnt", flush_cnt, 2);

    // Watchdog: DRAM never ready.
    dram_req = 1;
    for (int i = 0; i < 4; i++) cyc();
    settle();
    chk("wd_before", mem_timeout, 0);
    chk("wd_before_stall", stall_if, 1);
    cyc(); dram_req = 0; dram_ready = 1; redirect = 1; settle();
    chk("wd_timeout", mem_timeout, 1);
    chk("wd_stall_held", stall_mem, 1);
    chk("wd_no_flush", flush_id, 0);
    chk("wd_stall_cnt", stall_cnt, 8);
    for (int i = 0; i < 10; i++) cyc();
    chk("wd_cnt_sat", stall_cnt, 15);
    chk("wd_flush_cnt", flush_cnt, 2);
    rst = 1; settle();
    chk("wd_rst_force", stall_if, 0);
    cyc(); rst = 0; clr(); settle();
    chk("wd_rst_timeout", mem_timeout, 0);
    chk("wd_rst_stall", stall_if, 0);
    chk("wd_rst_cnt", stall_cnt, 0);

    // Reset in the middle of a wait returns to RUN.
    dram_req = 1;
    cyc(); cyc();
    rst = 1; cyc(); rst = 0; clr(); settle();
    chk("mid_rst_stall_mem", stall_mem, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    chk("mid_rst_flush_cnt", flush_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
